// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - sample ROM address scheduler for one music lane and N_REQ-1 effect lanes
//
// Purpose: shares one sample ROM address port between sound lanes. Lane 0 is
// looping background music, lanes 1..N_REQ-1 are one-shot effects. Sequences
// the codec init handshake, grants the highest requesting lane, steps the ROM
// address at the owning lane's own rate and reports one-shot completion.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous reset, active-low
//   i_init_finish  codec init complete (level)
//   i_data_over    codec ready for next sample (level qualifier)
//   i_bgm_en       background music enable (level)
//   i_req          one-cycle trigger per effect lane (bit 0 ignored)
//   i_seg_start    first sample address per lane, lane i at [i*ADDR_W +: ADDR_W]
//   i_seg_end      last sample address per lane (inclusive)
//   i_rate_div     cycles-per-sample minus 1, per lane
//   o_init         codec init request
//   o_add          sample ROM address
//   o_playing      a lane currently owns o_add
//   o_active_id    lane owning o_add
//   o_done         one-cycle pulse on natural completion of a one-shot
module sfx_scheduler #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 17,
  parameter int DIV_W  = 16,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_init_finish,
  input  logic                    i_data_over,
  input  logic                    i_bgm_en,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*ADDR_W-1:0] i_seg_start,
  input  logic [N_REQ*ADDR_W-1:0] i_seg_end,
  input  logic [N_REQ*DIV_W-1:0]  i_rate_div,
  output logic                    o_init,
  output logic [ADDR_W-1:0]       o_add,
  output logic                    o_playing,
  output logic [ID_W-1:0]         o_active_id,
  output logic [N_REQ-1:0]        o_done
);

  typedef enum logic [1:0] {S_WAIT_INIT, S_IDLE, S_PLAY} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_init;
  logic              r_playing;
  logic [ADDR_W-1:0] r_add;
  logic [ADDR_W-1:0] r_bgm_ptr;
  logic [ID_W-1:0]   r_active;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [N_REQ-1:0]  r_pending;
  logic [N_REQ-1:0]  r_done;

  logic [ADDR_W-1:0] w_start [N_REQ];
  logic [ADDR_W-1:0] w_end   [N_REQ];
  logic [DIV_W-1:0]  w_div   [N_REQ];
  logic [N_REQ-1:0]  w_reqs;
  logic [N_REQ-1:0]  w_req_in;
  logic [N_REQ-1:0]  w_clr;
  logic              w_hi_valid;
  logic [ID_W-1:0]   w_hi_idx;
  logic              w_grant;
  logic              w_tick;
  logic              w_advance;
  logic              w_last;
  logic              w_bgm_act;
  logic              w_stop_bgm;
  logic              w_oneshot_end;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_start[i] = i_seg_start[i*ADDR_W +: ADDR_W];
      w_end[i]   = i_seg_end[i*ADDR_W +: ADDR_W];
      w_div[i]   = i_rate_div[i*DIV_W +: DIV_W];
    end
  end

  // Lane 0 never latches a trigger; it requests for as long as music is enabled.
  assign w_req_in = i_req & {{(N_REQ-1){1'b1}}, 1'b0};
  assign w_reqs   = {r_pending[N_REQ-1:1], i_bgm_en};

  // Highest index wins: later iterations overwrite earlier ones.
  always_comb begin
    w_hi_valid = 1'b0;
    w_hi_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_reqs[i]) begin
        w_hi_valid = 1'b1;
        w_hi_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_bgm_act     = (r_active == '0);
    w_tick        = (r_div_cnt == w_div[r_active]);
    w_advance     = (r_state == S_PLAY) && w_tick && i_data_over;
    // ">=" also covers segments whose end lies before their start: one sample only.
    w_last        = (r_add >= w_end[r_active]) || (r_add == '1);
    w_stop_bgm    = (r_state == S_PLAY) && w_bgm_act && !i_bgm_en;
    w_oneshot_end = w_advance && w_last && !w_bgm_act;
    w_grant       = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant = w_hi_valid;
    end else if (r_state == S_PLAY) begin
      // Preempt by a higher lane, or restart the active lane on its own retrigger.
      w_grant = w_hi_valid && ((w_hi_idx > r_active) || r_pending[r_active]);
    end
    w_clr = '0;
    if (w_grant) begin
      w_clr[w_hi_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT_INIT: if (i_init_finish) w_state_next = S_IDLE;
      S_IDLE:      if (w_grant) w_state_next = S_PLAY;
      S_PLAY: begin
        if (w_grant) begin
          w_state_next = S_PLAY;
        end else if (w_stop_bgm || w_oneshot_end) begin
          w_state_next = S_IDLE;
        end
      end
      default:     w_state_next = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_WAIT_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_init    <= 1'b0;
      r_playing <= 1'b0;
      r_add     <= '0;
      r_active  <= '0;
      r_div_cnt <= '0;
      r_pending <= '0;
      r_done    <= '0;
      r_bgm_ptr <= w_start[0];
    end else begin
      r_init    <= 1'b1;
      r_done    <= '0;
      r_pending <= (r_pending & ~w_clr) | w_req_in;
      if (w_grant) begin
        r_active  <= w_hi_idx;
        r_add     <= (w_hi_idx == '0) ? r_bgm_ptr : w_start[w_hi_idx];
        r_playing <= 1'b1;
        r_div_cnt <= '0;
      end else if (r_state == S_PLAY) begin
        if (w_stop_bgm) begin
          r_playing <= 1'b0;
        end else begin
          r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
          if (w_advance) begin
            if (!w_last) begin
              r_add <= r_add + 1'b1;
            end else if (w_bgm_act) begin
              r_add <= w_start[0];
            end else begin
              r_done[r_active] <= 1'b1;
              r_playing        <= 1'b0;
            end
          end
        end
      end
      // While music is disabled the resume point tracks the segment start, so a
      // falling enable rewinds the music; a preempted music lane keeps its place.
      if (!i_bgm_en) begin
        r_bgm_ptr <= w_start[0];
      end else if (w_grant && (r_state == S_PLAY) && w_bgm_act && (w_hi_idx != '0)) begin
        r_bgm_ptr <= r_add;
      end
    end
  end

  assign o_init      = r_init;
  assign o_add       = r_add;
  assign o_playing   = r_playing;
  assign o_active_id = r_active;
  assign o_done      = r_done;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - directed self-checking bench for sfx_scheduler
module tb_sfx_scheduler;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 17;
  localparam int DIV_W  = 16;

  logic                    clk;
  logic                    reset;
  logic                    init_finish;
  logic                    data_over;
  logic                    bgm_en;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] seg_start;
  logic [N_REQ*ADDR_W-1:0] seg_end;
  logic [N_REQ*DIV_W-1:0]  rate_div;
  logic                    o_init;
  logic [ADDR_W-1:0]       o_add;
  logic                    o_playing;
  logic [1:0]              o_active_id;
  logic [N_REQ-1:0]        o_done;

  int checks;
  int errors;

  sfx_scheduler #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_init_finish(init_finish),
    .i_data_over  (data_over),
    .i_bgm_en     (bgm_en),
    .i_req        (req),
    .i_seg_start  (seg_start),
    .i_seg_end    (seg_end),
    .i_rate_div   (rate_div),
    .o_init       (o_init),
    .o_add        (o_add),
    .o_playing    (o_playing),
    .o_active_id  (o_active_id),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lane(input int lane, input int s, input int e, input int d);
    seg_start[lane*ADDR_W +: ADDR_W] = ADDR_W'(s);
    seg_end[lane*ADDR_W +: ADDR_W]   = ADDR_W'(e);
    rate_div[lane*DIV_W +: DIV_W]    = DIV_W'(d);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(3);
    checks++; if (o_init !== 1'b0) begin errors++; $display("FAIL rst_init got %0d want 0", o_init); end
    checks++; if (o_add !== 17'd0) begin errors++; $display("FAIL rst_add got %0d want 0", o_add); end
    checks++; if (o_playing !== 1'b0) begin errors++; $display("FAIL rst_playing got %0d want 0", o_playing); end
    checks++; if (o_done !== 4'b0000) begin errors++; $display("FAIL rst_done got %b want 0000", o_done); end
    checks++; if (o_active_id !== 2'd0) begin errors++; $display("FAIL rst_active got %0d want 0", o_active_id); end
    reset = 1'b1;
    step(1);
    checks++; if (o_init !== 1'b1) begin errors++; $display("FAIL init_after_rst got %0d want 1", o_init); end
    // A trigger while waiting for the codec must stay pending, not play.
    set_lane(1, 100, 103, 2);
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    step(3);
    checks++; if (o_playing !== 1'b0) begin errors++; $display("FAIL wait_init_held got %0d want 0", o_playing); end
  endtask

  task automatic test_single;
    init_finish = 1'b1;
    step(1);
    checks++; if (o_playing !== 1'b0) begin errors++; $display("FAIL idle_entry_playing got %0d want 0", o_playing); end
    step(1);
    checks++; if (o_add !== 17'd100) begin errors++; $display("FAIL t2_grant_add got %0d want 100", o_add); end
    checks++; if (o_playing !== 1'b1) begin errors++; $display("FAIL t2_grant_playing got %0d want 1", o_playing); end
    checks++; if (o_active_id !== 2'd1) begin errors++; $display("FAIL t2_grant_active got %0d want 1", o_active_id); end
    for (int k = 1; k <= 3; k++) begin
      step(2);
      checks++; if (o_add !== 17'(99 + k)) begin errors++; $display("FAIL t2_hold_add got %0d want %0d", o_add, 99 + k); end
      checks++; if (o_done !== 4'b0000) begin errors++; $display("FAIL t2_early_done got %b want 0000", o_done); end
      step(1);
      checks++; if (o_add !== 17'(100 + k)) begin errors++; $display("FAIL t2_step_add got %0d want %0d", o_add, 100 + k); end
    end
    step(2);
    checks++; if (o_playing !== 1'b1) begin errors++; $display("FAIL t2_last_playing got %0d want 1", o_playing); end
    step(1);
    checks++; if (o_done !== 4'b0010) begin errors++; $display("FAIL t2_done got %b want 0010", o_done); end
    checks++; if (o_playing !== 1'b0) begin errors++; $display("FAIL t2_end_playing got %0d want 0", o_playing); end
    checks++; if (o_add !== 17'd103) begin errors++; $display("FAIL t2_end_add got %0d want 103", o_add); end
    step(1);
    checks++; if (o_done !== 4'b0000) begin errors++; $display("FAIL t2_done_width got %b want 0000", o_done); end
  endtask

  task automatic test_bgm_preempt;
    set_lane(0, 0, 9, 0);
    set_lane(3, 200, 202, 0);
    bgm_en = 1'b1;
    step(1);
    checks++; if (o_add !== 17'd0 || o_playing !== 1'b1 || o_active_id !== 2'd0) begin
      errors++; $display("FAIL t3_bgm_start got add=%0d play=%0d id=%0d want 0 1 0", o_add, o_playing, o_active_id); end
    for (int k = 1; k <= 9; k++) begin
      step(1);
      checks++; if (o_add !== 17'(k)) begin errors++; $display("FAIL t3_bgm_add got %0d want %0d", o_add, k); end
    end
    step(1);
    checks++; if (o_add !== 17'd0) begin errors++; $display("FAIL t3_bgm_loop got %0d want 0", o_add); end
    step(4);
    req = 4'b1000;
    step(1);
    req = 4'b0000;
    checks++; if (o_add !== 17'd5) begin errors++; $display("FAIL t3_pre_preempt got %0d want 5", o_add); end
    step(1);
    checks++; if (o_add !== 17'd200 || o_active_id !== 2'd3) begin
      errors++; $display("FAIL t3_preempt got add=%0d id=%0d want 200 3", o_add, o_active_id); end
    step(2);
    checks++; if (o_add !== 17'd202) begin errors++; $display("FAIL t3_fx_add got %0d want 202", o_add); end
    step(1);
    checks++; if (o_done !== 4'b1000 || o_playing !== 1'b0) begin
      errors++; $display("FAIL t3_fx_done got done=%b play=%0d want 1000 0", o_done, o_playing); end
    step(1);
    checks++; if (o_add !== 17'd5 || o_active_id !== 2'd0 || o_playing !== 1'b1) begin
      errors++; $display("FAIL t3_resume got add=%0d id=%0d play=%0d want 5 0 1", o_add, o_active_id, o_playing); end
    checks++; if (o_done !== 4'b0000) begin errors++; $display("FAIL t3_bgm_no_done got %b want 0000", o_done); end
    bgm_en = 1'b0;
    step(1);
    checks++; if (o_playing !== 1'b0) begin errors++; $display("FAIL bgm_stop got %0d want 0", o_playing); end
    bgm_en = 1'b1;
    step(1);
    checks++; if (o_add !== 17'd0 || o_playing !== 1'b1) begin
      errors++; $display("FAIL bgm_rewind got add=%0d play=%0d want 0 1", o_add, o_playing); end
    bgm_en = 1'b0;
    step(1);
    checks++; if (o_playing !== 1'b0) begin errors++; $display("FAIL bgm_stop2 got %0d want 0", o_playing); end
  endtask

  task automatic test_two_req;
    set_lane(1, 300, 301, 1);
    set_lane(2, 400, 350, 0);
    req = 4'b0110;
    step(1);
    req = 4'b0000;
    step(1);
    checks++; if (o_add !== 17'd400 || o_active_id !== 2'd2) begin
      errors++; $display("FAIL t4_first got add=%0d id=%0d want 400 2", o_add, o_active_id); end
    step(1);
    checks++; if (o_done !== 4'b0100 || o_add !== 17'd400) begin
      errors++; $display("FAIL t4_done2 got done=%b add=%0d want 0100 400", o_done, o_add); end
    step(1);
    checks++; if (o_add !== 17'd300 || o_active_id !== 2'd1 || o_playing !== 1'b1) begin
      errors++; $display("FAIL t4_second got add=%0d id=%0d play=%0d want 300 1 1", o_add, o_active_id, o_playing); end
    step(2);
    checks++; if (o_add !== 17'd301) begin errors++; $display("FAIL t4_div1 got %0d want 301", o_add); end
    step(2);
    checks++; if (o_done !== 4'b0010 || o_playing !== 1'b0) begin
      errors++; $display("FAIL t4_done1 got done=%b play=%0d want 0010 0", o_done, o_playing); end
  endtask

  task automatic test_retrigger;
    set_lane(1, 600, 610, 0);
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    step(1);
    checks++; if (o_add !== 17'd600) begin errors++; $display("FAIL rt_start got %0d want 600", o_add); end
    step(2);
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    checks++; if (o_add !== 17'd603) begin errors++; $display("FAIL rt_pre got %0d want 603", o_add); end
    step(1);
    checks++; if (o_add !== 17'd600 || o_done !== 4'b0000) begin
      errors++; $display("FAIL rt_restart got add=%0d done=%b want 600 0000", o_add, o_done); end
  endtask

  task automatic test_stall_reset;
    set_lane(1, 500, 520, 0);
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    step(1);
    checks++; if (o_add !== 17'd500) begin errors++; $display("FAIL t5_start got %0d want 500", o_add); end
    step(1);
    data_over = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      checks++; if (o_add !== 17'd501) begin errors++; $display("FAIL t5_frozen got %0d want 501", o_add); end
    end
    data_over = 1'b1;
    step(1);
    checks++; if (o_add !== 17'd502) begin errors++; $display("FAIL t5_resume got %0d want 502", o_add); end
    reset = 1'b0;
    step(1);
    checks++; if (o_add !== 17'd0 || o_playing !== 1'b0 || o_init !== 1'b0 || o_active_id !== 2'd0 || o_done !== 4'b0000) begin
      errors++; $display("FAIL t5_reset got add=%0d play=%0d init=%0d id=%0d done=%b want 0 0 0 0 0000",
                         o_add, o_playing, o_init, o_active_id, o_done); end
    reset = 1'b1;
    step(2);
    checks++; if (o_done !== 4'b0000 || o_playing !== 1'b0) begin
      errors++; $display("FAIL t5_post_reset got done=%b play=%0d want 0000 0", o_done, o_playing); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    init_finish = 1'b0;
    data_over   = 1'b1;
    bgm_en      = 1'b0;
    req         = '0;
    seg_start   = '0;
    seg_end     = '0;
    rate_div    = '0;
    test_reset();
    test_single();
    test_bgm_preempt();
    test_two_req();
    test_retrigger();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
